// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - copies a byte-wide program ROM into 32-bit RAM words
module rom_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter logic [31:0] MAX_BYTES = 32'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] rom_address,
    input  logic [7:0]  rom_byte,
    input  logic        rom_done,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data,
    output logic        ram_write,
    input  logic        ram_ready,
    output logic        busy,
    output logic        finished,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  lane;
    logic [29:0] word_index;
    // set when the word in WRITE is a zero-padded tail; the load ends after it
    logic        last_word;

    // status strobes decode straight from the state register
    assign ram_write = (state == WRITE);
    assign busy      = (state == FETCH) || (state == WRITE);
    assign finished  = (state == DONE);

    // load sequencer: ram_data doubles as the word assembly register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rom_address <= 32'd0;
            ram_address <= BASE_ADDR;
            ram_data    <= 32'd0;
            overflow    <= 1'b0;
            lane        <= 2'd0;
            word_index  <= 30'd0;
            last_word   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= FETCH;
                        rom_address <= 32'd0;
                        ram_address <= BASE_ADDR;
                        ram_data    <= 32'd0;
                        overflow    <= 1'b0;
                        lane        <= 2'd0;
                        word_index  <= 30'd0;
                        last_word   <= 1'b0;
                    end
                end
                FETCH: begin
                    if (rom_done) begin
                        // an empty trailing word is never written
                        if (lane == 2'd0) begin
                            state <= DONE;
                        end else begin
                            state     <= WRITE;
                            last_word <= 1'b1;
                        end
                    end else if (rom_address >= MAX_BYTES) begin
                        // runaway program: drop the partial word and abort
                        state    <= DONE;
                        overflow <= 1'b1;
                        ram_data <= 32'd0;
                        lane     <= 2'd0;
                    end else begin
                        ram_data[{lane, 3'b000} +: 8] <= rom_byte;
                        rom_address <= rom_address + 32'd1;
                        lane        <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // outputs hold until the RAM takes the word
                    if (ram_ready) begin
                        word_index  <= word_index + 30'd1;
                        ram_address <= BASE_ADDR + {word_index + 30'd1, 2'b00};
                        ram_data    <= 32'd0;
                        state       <= last_word ? DONE : FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader
module tb_rom_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, ram_ready;
    logic [31:0] rom_address, ram_address, ram_data;
    logic [7:0]  rom_byte;
    logic        rom_done, ram_write, busy, finished, overflow;

    logic        o_start;
    logic [31:0] o_rom_address, o_ram_address, o_ram_data;
    logic [7:0]  o_rom_byte;
    logic        o_rom_done, o_ram_ready, o_ram_write, o_busy, o_finished, o_overflow;

    logic [7:0]  prog  [0:255];
    logic [7:0]  oprog [0:15];
    int          prog_len;

    int          tests = 0;
    int          fails = 0;
    int          accepts = 0;
    int          o_accepts = 0;
    logic [63:0] sb  [$];
    logic [63:0] osb [$];

    assign rom_byte    = (rom_address < 32'd256) ? prog[rom_address[7:0]] : 8'h00;
    assign rom_done    = (rom_address == 32'(prog_len));
    assign o_rom_byte  = (o_rom_address < 32'd16) ? oprog[o_rom_address[3:0]] : 8'h00;
    assign o_rom_done  = 1'b0;
    assign o_ram_ready = 1'b1;

    rom_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_address(rom_address), .rom_byte(rom_byte), .rom_done(rom_done),
        .ram_address(ram_address), .ram_data(ram_data), .ram_write(ram_write),
        .ram_ready(ram_ready), .busy(busy), .finished(finished), .overflow(overflow)
    );

    rom_loader #(.BASE_ADDR(32'hFFFF_FFFC), .MAX_BYTES(32'd8)) dut_ovf (
        .clk(clk), .rst_n(rst_n), .start(o_start),
        .rom_address(o_rom_address), .rom_byte(o_rom_byte), .rom_done(o_rom_done),
        .ram_address(o_ram_address), .ram_data(o_ram_data), .ram_write(o_ram_write),
        .ram_ready(o_ram_ready), .busy(o_busy), .finished(o_finished), .overflow(o_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // accepted writes are popped from the scoreboard
    always @(negedge clk) begin
        if (rst_n && ram_write && ram_ready) begin
            accepts++;
            if (sb.size() == 0) begin
                check("write_expected", 32'(sb.size()), 32'd1);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("wr_addr", ram_address, e[63:32]);
                check("wr_data", ram_data, e[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && o_ram_write && o_ram_ready) begin
            o_accepts++;
            if (osb.size() == 0) begin
                check("ovf_write_expected", 32'(osb.size()), 32'd1);
            end else begin
                logic [63:0] e;
                e = osb.pop_front();
                check("ovf_wr_addr", o_ram_address, e[63:32]);
                check("ovf_wr_data", o_ram_data, e[31:0]);
            end
        end
    end

    task automatic build_prog196();
        for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
        prog[0] = 8'h01; prog[1] = 8'h00; prog[2]  = 8'h00; prog[3]  = 8'h00;
        prog[4] = 8'h01; prog[5] = 8'h00; prog[6]  = 8'h00; prog[7]  = 8'h00;
        prog[8] = 8'h05; prog[9] = 8'h00; prog[10] = 8'h00; prog[11] = 8'h00;
        prog[16] = 8'h0E; prog[17] = 8'h01; prog[18] = 8'h00; prog[19] = 8'h00;
        prog_len = 196;
    endtask

    task automatic build_prog6();
        prog[0] = 8'hAA; prog[1] = 8'hBB; prog[2] = 8'hCC;
        prog[3] = 8'hDD; prog[4] = 8'h11; prog[5] = 8'h22;
        prog_len = 6;
    endtask

    // little-endian words, tail lanes padded with zero
    task automatic push_expect(input logic [31:0] base, input int len);
        logic [31:0] d;
        for (int w = 0; w * 4 < len; w++) begin
            d = 32'd0;
            for (int b = 0; b < 4; b++)
                if (w * 4 + b < len) d[b*8 +: 8] = prog[w*4+b];
            sb.push_back({base + 32'(w * 4), d});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // counts edges from leaving IDLE until finished; optional stray start while busy
    task automatic wait_done(input int budget, input bit spur, output int cyc);
        cyc = 0;
        while (!finished && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (spur && cyc == 20) start = 1'b1;
            if (spur && cyc == 22) start = 1'b0;
        end
        check("finished", 32'(finished), 32'd1);
    endtask

    initial begin
        int cyc;
        int n;
        rst_n = 1'b0; start = 1'b0; o_start = 1'b0; ram_ready = 1'b1;
        build_prog196();
        for (int i = 0; i < 16; i++) oprog[i] = 8'($urandom);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rom_addr", rom_address, 32'd0);
        check("rst_ram_addr", ram_address, 32'd0);
        check("rst_ram_data", ram_data, 32'd0);
        check("rst_ram_write", 32'(ram_write), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_finished", 32'(finished), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ovf_ram_addr", o_ram_address, 32'hFFFF_FFFC);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_write", 32'(ram_write), 32'd0);

        // 196-byte load, ready tied high, stray start while busy
        push_expect(32'd0, 196);
        accepts = 0;
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(400, 1'b1, cyc);
        check("load_cycles", 32'(cyc), 32'd246);
        check("load_overflow", 32'(overflow), 32'd0);
        check("load_writes", 32'(accepts), 32'd49);
        check("load_sb_empty", 32'(sb.size()), 32'd0);
        check("load_rom_addr", rom_address, 32'd196);

        // restart from DONE with backpressure on the first write
        push_expect(32'd0, 196);
        accepts = 0;
        @(posedge clk); #1 ram_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!ram_write && n < 20) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 4; i++) begin
            check("bp_write", 32'(ram_write), 32'd1);
            check("bp_addr", ram_address, 32'd0);
            check("bp_data", ram_data, 32'h0000_0001);
            check("bp_rom_addr", rom_address, 32'd4);
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        ram_ready = 1'b1;
        wait_done(400, 1'b1, cyc);
        check("restart_writes", 32'(accepts), 32'd49);
        check("restart_sb_empty", 32'(sb.size()), 32'd0);
        check("restart_overflow", 32'(overflow), 32'd0);

        // partial trailing word
        build_prog6();
        push_expect(32'd0, 6);
        accepts = 0;
        pulse_start();
        wait_done(50, 1'b0, cyc);
        check("part_cycles", 32'(cyc), 32'd9);
        check("part_writes", 32'(accepts), 32'd2);
        check("part_sb_empty", 32'(sb.size()), 32'd0);
        check("part_rom_addr", rom_address, 32'd6);
        check("part_overflow", 32'(overflow), 32'd0);

        // reset asserted while stalled in the fifth WRITE
        build_prog196();
        push_expect(32'd0, 196);
        accepts = 0;
        pulse_start();
        n = 0;
        while (!(accepts == 4 && ram_write) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        ram_ready = 1'b0;
        check("mid_in_write5", 32'(ram_write), 32'd1);
        check("mid_addr5", ram_address, 32'h10);
        check("mid_data5", ram_data, 32'h0000_010E);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rom_addr", rom_address, 32'd0);
        check("mid_rst_ram_addr", ram_address, 32'd0);
        check("mid_rst_ram_data", ram_data, 32'd0);
        check("mid_rst_write", 32'(ram_write), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_finished", 32'(finished), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1; ram_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(busy), 32'd0);
        build_prog6();
        push_expect(32'd0, 6);
        accepts = 0;
        pulse_start();
        wait_done(50, 1'b0, cyc);
        check("reload_writes", 32'(accepts), 32'd2);
        check("reload_sb_empty", 32'(sb.size()), 32'd0);

        // overflow abort on the MAX_BYTES=8 instance; addresses wrap past 2^32
        osb.push_back({32'hFFFF_FFFC, oprog[3], oprog[2], oprog[1], oprog[0]});
        osb.push_back({32'h0000_0000, oprog[7], oprog[6], oprog[5], oprog[4]});
        o_accepts = 0;
        @(posedge clk); #1 o_start = 1'b1;
        @(posedge clk); #1 o_start = 1'b0;
        n = 0;
        while (!o_finished && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("ovf_finished", 32'(o_finished), 32'd1);
        check("ovf_flag", 32'(o_overflow), 32'd1);
        check("ovf_rom_addr", o_rom_address, 32'd8);
        check("ovf_writes", 32'(o_accepts), 32'd2);
        check("ovf_sb_empty", 32'(osb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
